// File: rtl/cell_stream_ibuf.sv
// cell_stream_ibuf
// Packet input buffer: captures one-cycle-strobed 4-word stream packets
// (header, datax, datay, datas) into a small packet FIFO and serializes
// each packet as four 32-bit AXI-stream beats with tvalid/tready/tlast.
//
// Optional feature macro: CELL_STREAM_IBUF_DROP_CNT_EN
//   defined   -> drop_count counts dropped packets, saturating at 0xFFFF
//   undefined -> drop counter omitted, drop_count tied to 0
//
// All outputs are decoded from registered state only; tready and the
// stream_in_* inputs never reach tvalid/tlast/tdata/full combinationally.
module cell_stream_ibuf #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stream_in_valid,
  input  logic [31:0] stream_in_header,
  input  logic [31:0] stream_in_datax,
  input  logic [31:0] stream_in_datay,
  input  logic [31:0] stream_in_datas,
  output logic        tvalid,
  input  logic        tready,
  output logic        tlast,
  output logic [31:0] tdata,
  output logic        full,
  output logic [15:0] drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // Packet storage: slot s occupies words {s, beat}, beat 0..3.
  logic [31:0]           r_mem [0:DEPTH*4-1];

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [1:0]            r_beat;

  logic w_tvalid;
  logic w_xfer;
  logic w_pop;
  logic w_push;

  // A beat leaves when the head packet is presented and the sink is ready.
  // The last beat of a packet frees its slot, which a simultaneous push may
  // reuse on the same edge even when the FIFO is full.
  assign w_tvalid = (r_count != '0);
  assign w_xfer   = w_tvalid && tready;
  assign w_pop    = w_xfer && (r_beat == 2'd3);
  assign w_push   = stream_in_valid && ((r_count < DEPTH_CNT) || w_pop);

  // Output decode from registered state; tdata is forced to 0 while idle.
  assign tvalid = w_tvalid;
  assign tlast  = w_tvalid && (r_beat == 2'd3);
  assign tdata  = w_tvalid ? r_mem[{r_rd_ptr, r_beat}] : 32'h0;
  assign full   = (r_count == DEPTH_CNT);

  // Write an accepted packet into the slot at the write pointer. Storage is
  // not cleared by reset; pushes are ignored while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[{r_wr_ptr, 2'd0}] <= stream_in_header;
      r_mem[{r_wr_ptr, 2'd1}] <= stream_in_datax;
      r_mem[{r_wr_ptr, 2'd2}] <= stream_in_datay;
      r_mem[{r_wr_ptr, 2'd3}] <= stream_in_datas;
    end
  end

  // Write pointer advances one slot per accepted packet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Beat index walks 0..3 through the head packet; wrapping to 0 pops it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat   <= 2'd0;
      r_rd_ptr <= '0;
    end else if (w_xfer) begin
      r_beat <= r_beat + 2'd1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Packet occupancy: a push and a pop on the same edge cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      r_count <= r_count - 1'b1;
    end
  end

`ifdef CELL_STREAM_IBUF_DROP_CNT_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  // A strobe that cannot be stored is dropped whole.
  assign w_drop = stream_in_valid && !w_push;

  // Saturating count of dropped packets, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= 16'h0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'h1;
    end
  end

  assign drop_count = r_drop_cnt;
`else
  assign drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_cell_stream_ibuf.sv
// Testbench for cell_stream_ibuf: directed scenarios plus a randomized run,
// all checked against a packet-queue reference model.
module tb_cell_stream_ibuf;

  localparam int DEPTH = 4;
`ifdef CELL_STREAM_IBUF_DROP_CNT_EN
  localparam int DROP_ONE = 1;
`else
  localparam int DROP_ONE = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stream_in_valid = 1'b0;
  logic [31:0] stream_in_header = '0;
  logic [31:0] stream_in_datax = '0;
  logic [31:0] stream_in_datay = '0;
  logic [31:0] stream_in_datas = '0;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        tlast;
  logic [31:0] tdata;
  logic        full;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of whole packets, word 0 in bits [31:0].
  logic [127:0] mq[$];
  int           mbeat = 0;
  int           mdrop = 0;

  cell_stream_ibuf #(.DEPTH_LOG2(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stream_in_valid  (stream_in_valid),
    .stream_in_header (stream_in_header),
    .stream_in_datax  (stream_in_datax),
    .stream_in_datay  (stream_in_datay),
    .stream_in_datas  (stream_in_datas),
    .tvalid           (tvalid),
    .tready           (tready),
    .tlast            (tlast),
    .tdata            (tdata),
    .full             (full),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic exp_tvalid();
    return mq.size() != 0;
  endfunction

  function automatic logic [31:0] exp_tdata();
    logic [127:0] p;
    if (mq.size() == 0) return 32'h0;
    p = mq[0];
    return p[32*mbeat +: 32];
  endfunction

  function automatic logic exp_tlast();
    return (mq.size() != 0) && (mbeat == 3);
  endfunction

  function automatic logic exp_full();
    return mq.size() == DEPTH;
  endfunction

  // One clock: drive inputs, advance the model by the interface rules, then
  // leave the time pointer 1 unit after the edge for sampling.
  task automatic cyc(input logic v, input logic [31:0] h, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] s, input logic r);
    logic         mv, mx, mp, mpush;
    logic [127:0] tmp;
    stream_in_valid  = v;
    stream_in_header = h;
    stream_in_datax  = x;
    stream_in_datay  = y;
    stream_in_datas  = s;
    tready           = r;
    mv    = mq.size() != 0;
    mx    = mv && r;
    mp    = mx && (mbeat == 3);
    mpush = v && ((mq.size() < DEPTH) || mp);
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      mbeat = 0;
      mdrop = 0;
    end else begin
      if (mx) begin
        if (mp) begin
          tmp   = mq.pop_front();
          mbeat = 0;
        end else begin
          mbeat++;
        end
      end
      if (mpush) mq.push_back({s, y, x, h});
`ifdef CELL_STREAM_IBUF_DROP_CNT_EN
      else if (v && mdrop < 65535) mdrop++;
`endif
    end
    #1;
    stream_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 0, 0, 0, 0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(1'b0, 0, 0, 0, 0, 1'b0);
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    rst_n = 1'b1;
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
    checks++;
    if (tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h want 0", tdata); end
    checks++;
    if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", tlast); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++;
    if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop: got %h want 0", drop_count); end
  endtask

  task automatic test_single();
    logic [31:0] w [4];
    w = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_reset();
    cyc(1'b1, w[0], w[1], w[2], w[3], 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== w[i] || tlast !== (i == 3)) begin
        errors++;
        $display("FAIL single_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, tvalid, tdata, tlast, w[i], (i == 3));
      end
      cyc(1'b0, 0, 0, 0, 0, 1'b1);
    end
    checks++;
    if (tvalid !== 1'b0 || tdata !== 32'h0) begin
      errors++; $display("FAIL single_idle: got v=%b d=%h want v=0 d=0", tvalid, tdata);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [4];
    w = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_reset();
    cyc(1'b1, w[0], w[1], w[2], w[3], 1'b0);
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'h22 || tlast !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b d=%h l=%b want v=1 d=00000022 l=0", i, tvalid, tdata, tlast);
      end
      cyc(1'b0, 0, 0, 0, 0, 1'b0);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== w[i]) begin
        errors++; $display("FAIL bp_beat%0d: got v=%b d=%h want v=1 d=%h", i, tvalid, tdata, w[i]);
      end
      cyc(1'b0, 0, 0, 0, 0, 1'b1);
    end
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL bp_idle: got v=%b want 0", tvalid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, i, $urandom, $urandom, $urandom, 1'b0);
      if (i == 4) begin
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full); end
      end
    end
    checks++;
    if (drop_count !== 16'(DROP_ONE)) begin
      errors++; $display("FAIL ovf_drop: got %0d want %0d", drop_count, DROP_ONE);
    end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL ovf_full2: got %b want 1", full); end
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 0) begin
        checks++;
        if (tdata !== 32'(k / 4 + 1)) begin
          errors++; $display("FAIL ovf_hdr%0d: got %h want %h", k / 4, tdata, 32'(k / 4 + 1));
        end
      end
      cyc(1'b0, 0, 0, 0, 0, 1'b1);
    end
    checks++;
    if (tvalid !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL ovf_drain: got v=%b f=%b want v=0 f=0", tvalid, full);
    end
  endtask

  task automatic test_simul();
    logic [31:0] hdr [4];
    hdr = '{32'h2, 32'h3, 32'h4, 32'hA5};
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, i, $urandom, $urandom, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 0, 0, 0, 1'b1);
    checks++;
    if (tlast !== 1'b1 || full !== 1'b1) begin
      errors++; $display("FAIL simul_pre: got l=%b f=%b want l=1 f=1", tlast, full);
    end
    cyc(1'b1, 32'hA5, 32'hB6, 32'hC7, 32'hD8, 1'b1);
    checks++;
    if (full !== 1'b1 || drop_count !== 16'h0) begin
      errors++; $display("FAIL simul_acc: got f=%b drop=%0d want f=1 drop=0", full, drop_count);
    end
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 0) begin
        checks++;
        if (tdata !== hdr[k / 4]) begin
          errors++; $display("FAIL simul_hdr%0d: got %h want %h", k / 4, tdata, hdr[k / 4]);
        end
      end
      if (k == 15) begin
        checks++;
        if (tdata !== 32'hD8 || tlast !== 1'b1) begin
          errors++; $display("FAIL simul_last: got d=%h l=%b want d=000000d8 l=1", tdata, tlast);
        end
      end
      cyc(1'b0, 0, 0, 0, 0, 1'b1);
    end
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL simul_idle: got v=%b want 0", tvalid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1'b1, 32'h11, 32'h22, 32'h33, 32'h44, 1'b1);
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    rst_n = 1'b0;
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    rst_n = 1'b1;
    checks++;
    if (tvalid !== 1'b0 || tdata !== 32'h0 || full !== 1'b0) begin
      errors++; $display("FAIL rstmid_out: got v=%b d=%h f=%b want 0 0 0", tvalid, tdata, full);
    end
    cyc(1'b1, 32'h55, 32'h66, 32'h77, 32'h88, 1'b1);
    checks++;
    if (tvalid !== 1'b1 || tdata !== 32'h55) begin
      errors++; $display("FAIL rstmid_hdr: got v=%b d=%h want v=1 d=00000055", tvalid, tdata);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      cyc(($urandom % 3) != 0, $urandom, $urandom, $urandom, $urandom, ($urandom % 4) != 0 || n > 780);
      checks++;
      if (tvalid !== exp_tvalid() || tdata !== exp_tdata() || tlast !== exp_tlast() ||
          full !== exp_full() || drop_count !== 16'(mdrop)) begin
        errors++;
        $display("FAIL rnd_cyc%0d: got v=%b d=%h l=%b f=%b dc=%0d want v=%b d=%h l=%b f=%b dc=%0d",
                 n, tvalid, tdata, tlast, full, drop_count,
                 exp_tvalid(), exp_tdata(), exp_tlast(), exp_full(), mdrop);
      end
    end
  endtask

`ifdef CELL_STREAM_IBUF_DROP_CNT_EN
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, i, 0, 0, 0, 1'b0);
    for (int i = 0; i < 70000; i++) cyc(1'b1, 32'hDEAD, 0, 0, 0, 1'b0);
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_drop: got %h want ffff", drop_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_simul();
    test_reset_mid();
    test_random();
`ifdef CELL_STREAM_IBUF_DROP_CNT_EN
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
